// File: rtl/alu_ctrl.sv
// Execute-stage sequencer for the 8-bit ALU: accepts one instruction, optionally fetches a memory operand,
// drives the ALU and commits WREG/STATUS. Optional feature macro: ALU_CTRL_PRESERVE_CARRY_EN.
module alu_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [3:0] instr_op,
    input  logic       instr_imm,
    input  logic [7:0] instr_arg,
    input  logic       wreg_wr,
    input  logic [7:0] wreg_wdata,
    output logic       mem_rd,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rdata,
    output logic [3:0] alu_opcode,
    output logic [7:0] alu_wreg,
    output logic [7:0] alu_p,
    input  logic [7:0] alu_res,
    input  logic [2:0] alu_status,
    output logic [7:0] wreg,
    output logic [2:0] status,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, EXEC = 2'd2} state_t;

    localparam logic [3:0] OP_ZEROW = 4'd0;
    localparam logic [3:0] OP_BNOTW = 4'd1;
    localparam logic [3:0] OP_DECRW = 4'd4;
    localparam logic [3:0] OP_CMPWP = 4'd7;
    localparam logic [3:0] OP_ANDWP = 4'd8;
    localparam logic [3:0] OP_IORWP = 4'd9;
    localparam logic [3:0] OP_XORWP = 4'd10;
    localparam logic [3:0] OP_LAST  = 4'd12;

    state_t     state_r, state_nxt_s;
    logic [3:0] op_r;
    logic       imm_r;
    logic [7:0] arg_r;
    logic [7:0] wreg_r;
    logic [2:0] status_r;
    logic       done_r, err_r, mem_rd_r;
    logic [7:0] mem_addr_r;
    logic       accept_s, illegal_s, mem_rd_nxt_s;
    logic [7:0] mem_addr_nxt_s;
    logic [3:0] alu_opcode_s;
    logic [7:0] alu_p_s;

    function automatic logic is_unary(input logic [3:0] op);
        return (op <= OP_DECRW);
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return (op <= OP_LAST);
    endfunction

    // Logic ops carry no meaningful carry; optionally keep the previous one.
    function automatic logic [2:0] next_status(input logic [3:0] op, input logic [2:0] flags,
                                               input logic [2:0] prev);
`ifdef ALU_CTRL_PRESERVE_CARRY_EN
        logic keep;
        keep = (op == OP_ZEROW) || (op == OP_BNOTW) || (op == OP_ANDWP) ||
               (op == OP_IORWP) || (op == OP_XORWP);
        return keep ? {prev[2], flags[1:0]} : flags;
`else
        logic unused;
        unused = ^{op, prev};
        return flags;
`endif
    endfunction

    assign instr_ready = (state_r == IDLE) && !wreg_wr;
    assign alu_wreg    = wreg_r;
    assign alu_opcode  = alu_opcode_s;
    assign alu_p       = alu_p_s;
    assign wreg        = wreg_r;
    assign status      = status_r;
    assign done        = done_r;
    assign err         = err_r;
    assign mem_rd      = mem_rd_r;
    assign mem_addr    = mem_addr_r;

    // Next-state, acceptance and ALU drive decode.
    always_comb begin
        state_nxt_s    = state_r;
        accept_s       = 1'b0;
        illegal_s      = 1'b0;
        mem_rd_nxt_s   = 1'b0;
        mem_addr_nxt_s = 8'h00;
        alu_opcode_s   = OP_ZEROW;
        alu_p_s        = 8'h00;
        case (state_r)
            IDLE: begin
                if (instr_valid && !wreg_wr) begin
                    accept_s = 1'b1;
                    if (!is_legal(instr_op)) begin
                        illegal_s   = 1'b1;
                        state_nxt_s = IDLE;
                    end else if (is_unary(instr_op) || instr_imm) begin
                        state_nxt_s = EXEC;
                    end else begin
                        state_nxt_s    = FETCH;
                        mem_rd_nxt_s   = 1'b1;
                        mem_addr_nxt_s = instr_arg;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FETCH: state_nxt_s = EXEC;
            EXEC: begin
                alu_opcode_s = op_r;
                if (is_unary(op_r)) begin
                    alu_p_s = 8'h00;
                end else if (imm_r) begin
                    alu_p_s = arg_r;
                end else begin
                    alu_p_s = mem_rdata;
                end
                state_nxt_s = IDLE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, captured instruction, architectural registers and output pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            op_r       <= 4'd0;
            imm_r      <= 1'b0;
            arg_r      <= 8'h00;
            wreg_r     <= 8'h00;
            status_r   <= 3'b000;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            mem_rd_r   <= 1'b0;
            mem_addr_r <= 8'h00;
        end else begin
            state_r    <= state_nxt_s;
            done_r     <= (state_r == EXEC);
            err_r      <= illegal_s;
            mem_rd_r   <= mem_rd_nxt_s;
            mem_addr_r <= mem_addr_nxt_s;
            if (accept_s) begin
                op_r  <= instr_op;
                imm_r <= instr_imm;
                arg_r <= instr_arg;
            end
            if (state_r == EXEC) begin
                status_r <= next_status(op_r, alu_status, status_r);
                if (op_r != OP_CMPWP) begin
                    wreg_r <= alu_res;
                end
            end else if ((state_r == IDLE) && wreg_wr) begin
                wreg_r <= wreg_wdata;
            end
        end
    end

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed self-checking bench for alu_ctrl with a behavioural ALU and data memory.
module tb_alu_ctrl;

    localparam logic [3:0] ZEROW = 4'd0, BNOTW = 4'd1, NEGTW = 4'd2, INCRW = 4'd3, DECRW = 4'd4;
    localparam logic [3:0] ADDWP = 4'd5, SUBWP = 4'd6, CMPWP = 4'd7, ANDWP = 4'd8, IORWP = 4'd9;
    localparam logic [3:0] XORWP = 4'd10, SHFLW = 4'd11, SHFRW = 4'd12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [3:0] instr_op = 4'd0;
    logic       instr_imm = 1'b0;
    logic [7:0] instr_arg = 8'h00;
    logic       wreg_wr = 1'b0;
    logic [7:0] wreg_wdata = 8'h00;
    logic       mem_rd;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata = 8'h00;
    logic [3:0] alu_opcode;
    logic [7:0] alu_wreg, alu_p, alu_res;
    logic [2:0] alu_status;
    logic [7:0] wreg;
    logic [2:0] status;
    logic       done, err;

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] mem [256];

    alu_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_imm(instr_imm), .instr_arg(instr_arg),
        .wreg_wr(wreg_wr), .wreg_wdata(wreg_wdata), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .alu_opcode(alu_opcode), .alu_wreg(alu_wreg), .alu_p(alu_p),
        .alu_res(alu_res), .alu_status(alu_status), .wreg(wreg), .status(status),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    // Behavioural ALU: status = {carry/borrow, negative, zero}.
    logic [8:0] wide;
    always_comb begin
        wide = 9'd0;
        case (alu_opcode)
            ZEROW:  wide = 9'd0;
            BNOTW:  wide = {1'b0, ~alu_wreg};
            NEGTW:  wide = {1'b0, 8'h00 - alu_wreg};
            INCRW:  wide = {1'b0, alu_wreg + 8'h01};
            DECRW:  wide = {1'b0, alu_wreg - 8'h01};
            ADDWP:  wide = {1'b0, alu_wreg} + {1'b0, alu_p};
            SUBWP, CMPWP: wide = {1'b0, alu_wreg} - {1'b0, alu_p};
            ANDWP:  wide = {1'b0, alu_wreg & alu_p};
            IORWP:  wide = {1'b0, alu_wreg | alu_p};
            XORWP:  wide = {1'b0, alu_wreg ^ alu_p};
            SHFLW:  wide = {alu_wreg, 1'b0};
            SHFRW:  wide = {alu_wreg[0], 1'b0, alu_wreg[7:1]};
            default: wide = 9'd0;
        endcase
        alu_res    = wide[7:0];
        alu_status = {wide[8], wide[7], (wide[7:0] == 8'h00)};
    end

    task automatic load_wreg(input logic [7:0] v);
        @(negedge clk);
        wreg_wr = 1'b1;
        wreg_wdata = v;
        @(negedge clk);
        wreg_wr = 1'b0;
    endtask

    task automatic drive_instr(input logic [3:0] op, input logic imm, input logic [7:0] arg);
        instr_valid = 1'b1;
        instr_op = op;
        instr_imm = imm;
        instr_arg = arg;
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (wreg !== 8'h00) begin n_fail++; $display("FAIL reset_wreg got=%h exp=00", wreg); end
        n_checks++;
        if (status !== 3'b000) begin n_fail++; $display("FAIL reset_status got=%b exp=000", status); end
        n_checks++;
        if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", instr_ready); end
        n_checks++;
        if ({mem_rd, done, err} !== 3'b000) begin
            n_fail++; $display("FAIL reset_strobes got=%b exp=000", {mem_rd, done, err});
        end
    endtask

    task automatic test_wreg_priority;
        @(negedge clk);
        wreg_wr = 1'b1;
        wreg_wdata = 8'h5A;
        instr_valid = 1'b1;
        instr_op = ADDWP;
        instr_imm = 1'b1;
        instr_arg = 8'h01;
        #1;
        n_checks++;
        if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL prio_ready got=%b exp=0", instr_ready); end
        @(negedge clk);
        wreg_wr = 1'b0;
        instr_valid = 1'b0;
        n_checks++;
        if (wreg !== 8'h5A) begin n_fail++; $display("FAIL prio_wreg got=%h exp=5a", wreg); end
        n_checks++;
        if (alu_opcode !== ZEROW || mem_rd !== 1'b0) begin
            n_fail++; $display("FAIL prio_no_accept opcode=%h mem_rd=%b exp=0/0", alu_opcode, mem_rd);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || wreg !== 8'h5A) begin
            n_fail++; $display("FAIL prio_no_done done=%b wreg=%h exp=0/5a", done, wreg);
        end
    endtask

    task automatic test_imm_add;
        load_wreg(8'h21);
        drive_instr(ADDWP, 1'b1, 8'h2C);
        n_checks++;
        if (alu_p !== 8'h2C || alu_opcode !== ADDWP) begin
            n_fail++; $display("FAIL imm_exec alu_p=%h op=%h exp=2c/5", alu_p, alu_opcode);
        end
        n_checks++;
        if (done !== 1'b0 || instr_ready !== 1'b0) begin
            n_fail++; $display("FAIL imm_cycle1 done=%b ready=%b exp=0/0", done, instr_ready);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || instr_ready !== 1'b1) begin
            n_fail++; $display("FAIL imm_done done=%b ready=%b exp=1/1", done, instr_ready);
        end
        n_checks++;
        if (wreg !== 8'h4D || status !== 3'b000) begin
            n_fail++; $display("FAIL imm_result wreg=%h status=%b exp=4d/000", wreg, status);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL imm_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_mem_add;
        load_wreg(8'hC8);
        drive_instr(ADDWP, 1'b0, 8'h10);
        n_checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 8'h10) begin
            n_fail++; $display("FAIL mem_fetch mem_rd=%b addr=%h exp=1/10", mem_rd, mem_addr);
        end
        n_checks++;
        if (done !== 1'b0 || alu_opcode !== ZEROW) begin
            n_fail++; $display("FAIL mem_cycle1 done=%b op=%h exp=0/0", done, alu_opcode);
        end
        @(negedge clk);
        n_checks++;
        if (mem_rd !== 1'b0 || mem_addr !== 8'h00 || alu_p !== 8'h64) begin
            n_fail++; $display("FAIL mem_exec mem_rd=%b addr=%h alu_p=%h exp=0/00/64", mem_rd, mem_addr, alu_p);
        end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL mem_cycle2_done got=%b exp=0", done); end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || wreg !== 8'h2C || status !== 3'b100) begin
            n_fail++; $display("FAIL mem_commit done=%b wreg=%h status=%b exp=1/2c/100", done, wreg, status);
        end
    endtask

    task automatic test_carry_preserve;
        logic [2:0] exp_status;
`ifdef ALU_CTRL_PRESERVE_CARRY_EN
        exp_status = 3'b110;
`else
        exp_status = 3'b010;
`endif
        @(negedge clk);
        drive_instr(XORWP, 1'b1, 8'hFF);
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || wreg !== 8'hD3) begin
            n_fail++; $display("FAIL xor_result done=%b wreg=%h exp=1/d3", done, wreg);
        end
        n_checks++;
        if (status !== exp_status) begin
            n_fail++; $display("FAIL xor_status got=%b exp=%b", status, exp_status);
        end
    endtask

    task automatic test_cmp;
        load_wreg(8'h50);
        drive_instr(CMPWP, 1'b1, 8'h50);
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || wreg !== 8'h50 || status !== 3'b001) begin
            n_fail++; $display("FAIL cmp done=%b wreg=%h status=%b exp=1/50/001", done, wreg, status);
        end
    endtask

    task automatic test_unary;
        drive_instr(INCRW, 1'b0, 8'hAA);
        n_checks++;
        if (alu_p !== 8'h00 || mem_rd !== 1'b0) begin
            n_fail++; $display("FAIL unary_exec alu_p=%h mem_rd=%b exp=00/0", alu_p, mem_rd);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || wreg !== 8'h51 || status !== 3'b000) begin
            n_fail++; $display("FAIL unary done=%b wreg=%h status=%b exp=1/51/000", done, wreg, status);
        end
    endtask

    task automatic test_illegal;
        @(negedge clk);
        drive_instr(4'hE, 1'b1, 8'h33);
        n_checks++;
        if (err !== 1'b1 || done !== 1'b0 || instr_ready !== 1'b1) begin
            n_fail++; $display("FAIL illegal_err err=%b done=%b ready=%b exp=1/0/1", err, done, instr_ready);
        end
        @(negedge clk);
        n_checks++;
        if (err !== 1'b0 || done !== 1'b0 || wreg !== 8'h51 || status !== 3'b000) begin
            n_fail++; $display("FAIL illegal_state err=%b done=%b wreg=%h status=%b exp=0/0/51/000",
                               err, done, wreg, status);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        drive_instr(ADDWP, 1'b0, 8'h10);
        n_checks++;
        if (mem_rd !== 1'b1) begin n_fail++; $display("FAIL rst_mid_fetch mem_rd=%b exp=1", mem_rd); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_rd !== 1'b0 || mem_addr !== 8'h00 || wreg !== 8'h00 || status !== 3'b000) begin
            n_fail++; $display("FAIL rst_mid_async mem_rd=%b addr=%h wreg=%h status=%b exp=0/00/00/000",
                               mem_rd, mem_addr, wreg, status);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || mem_rd !== 1'b0) begin
                n_fail++; $display("FAIL rst_mid_quiet cycle=%0d done=%b mem_rd=%b exp=0/0", i, done, mem_rd);
            end
        end
        n_checks++;
        if (instr_ready !== 1'b1 || wreg !== 8'h00) begin
            n_fail++; $display("FAIL rst_mid_ready ready=%b wreg=%h exp=1/00", instr_ready, wreg);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[16] = 8'h64;
        test_reset();
        test_wreg_priority();
        test_imm_add();
        test_mem_add();
        test_carry_preserve();
        test_cmp();
        test_unary();
        test_illegal();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Execute-stage sequencer for the 8-bit ALU. Accepts one ALU instruction at a time over a valid/ready handshake and, for memory operands, fetches the operand from data memory. It drives the combinational ALU, then commits the result to the working register (WREG) and the 3-bit status register. It sits between the instruction decoder and the ALU and owns the architectural WREG and STATUS state.

## Interface
No parameters; widths are fixed by the ALU (8-bit data, 4-bit opcode, 3-bit status).
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  decoder presents an instruction
- instr_ready  out  1  controller can accept; high only in IDLE with wreg_wr low
- instr_op  in  4  ALU opcode (ZEROW..SHFRW encodings 0..12)
- instr_imm  in  1  1: instr_arg is the p operand; 0: instr_arg is a memory address
- instr_arg  in  8  immediate value or operand address
- wreg_wr  in  1  external WREG load (MOV path), honoured in IDLE only
- wreg_wdata  in  8  data for wreg_wr
- mem_rd  out  1  data-memory read strobe
- mem_addr  out  8  read address; 0 when mem_rd is low
- mem_rdata  in  8  read data, valid the cycle after mem_rd
- alu_opcode  out  4  to ALU opcode
- alu_wreg  out  8  to ALU WREG input (always equals wreg)
- alu_p  out  8  to ALU p input
- alu_res  in  8  ALU result
- alu_status  in  3  ALU flags: [0] zero, [1] negative, [2] carry
- wreg  out  8  working register
- status  out  3  status register, same bit map as alu_status
- done  out  1  one-cycle pulse, instruction committed
- err  out  1  one-cycle pulse, illegal opcode dropped

## Operation
- Reset values: wreg=8'h00, status=3'b000, done=0, err=0, state=IDLE, mem_rd=0.
- FSM states:
  - IDLE: accepts on instr_valid & instr_ready. Captures op, imm, and arg.
    - Illegal op (13..15) goes to IDLE and pulses err.
    - Unary op (ZEROW, BNOTW, NEGTW, INCRW, DECRW) goes to EXEC.
    - Otherwise, instr_imm=1 goes to EXEC and instr_imm=0 goes to FETCH.
  - FETCH: mem_rd=1, mem_addr=arg. Goes to EXEC.
  - EXEC: alu_opcode=op and alu_p is selected as follows:
    - unary op: 8'h00
    - immediate: arg
    - memory: mem_rdata
  - EXEC commit:
    - status <= alu_status on every legal op.
    - wreg <= alu_res for every op except CMPWP, which leaves wreg unchanged.
    - Goes to IDLE.
- Outside EXEC, alu_opcode=ZEROW and alu_p=8'h00.
- wreg_wr in IDLE loads wreg <= wreg_wdata and leaves status unchanged. It takes priority: instr_ready is low that cycle, so no instruction is accepted.
- wreg_wr outside IDLE is ignored (the decoder must hold it).
- instr_valid outside IDLE is not accepted; the decoder holds the instruction stable until accepted.
- Shift amounts and arithmetic are entirely the ALU's; the controller does no width extension.

## Timing
- E0 is the accepting edge.
- Immediate or unary op:
  - EXEC occupies cycle 1.
  - wreg and status update at E1.
  - done is high during cycle 2, and instr_ready is high again in cycle 2.
  - Throughput: one instruction per 2 cycles.
- Memory op:
  - FETCH occupies cycle 1, EXEC cycle 2.
  - Commit at E2, done in cycle 3.
- Illegal op: err is high during cycle 1. No state change; ready in cycle 1.
- done and err are registered and never high together.
- Reset mid-instruction, asserted in any state:
  - Outputs go immediately to reset values.
  - The in-flight instruction is discarded with no done.
  - mem_rd drops asynchronously.

## Configuration
- ALU_CTRL_PRESERVE_CARRY_EN
  - Defined: for ZEROW, BNOTW, ANDWP, IORWP, XORWP, the commit keeps the previous status[2]. Bits [1:0] are still taken from alu_status.
  - Undefined: status <= alu_status verbatim for all legal ops.

## Test plan
- Reset: hold rst_n=0, release -> wreg=00, status=000, instr_ready=1, mem_rd=0, done=0.
- Immediate ADDWP: wreg_wr 0x21, then ADDWP imm 0x2C -> alu_p=0x2C in EXEC, wreg=0x4D, status=000, done exactly 2 cycles after accept.
- Memory ADDWP: wreg=0xC8, ADDWP addr 0x10 with mem[0x10]=0x64 -> mem_rd one cycle with addr 0x10, wreg=0x2C, status=100, done 3 cycles after accept.
- CMPWP: wreg=0x50, CMPWP imm 0x50 -> wreg stays 0x50, status=001.
- Carry preservation: after the memory ADDWP above (carry=1), XORWP imm 0xFF with wreg=0x2C -> wreg=0xD3.
  - status=110 with ALU_CTRL_PRESERVE_CARRY_EN.
  - status=010 without it.
- Illegal and reset: opcode 4'hE -> err pulse in cycle 1, wreg and status unchanged. Then a memory op with rst_n pulsed low during FETCH -> mem_rd=0, wreg=00, no done, instr_ready=1 after release.
